mips_alu: RTL and testbench

Execute-stage ALU for the MIPS core, directly downstream of the ALU control decoder: it consumes the 4-bit `ctrl_command` together with two operands and produces a registered result with zero and overflow flags. Logic operations, ADD and SUB complete in one cycle. MUL is a multi-cycle unsigned shift-add that produces a 2×WIDTH product. A valid/ready handshake on the input lets the pipeline stall while a multiply is in flight.

---
 rtl/mips_alu.sv | 145 ++++++++++++++
 tb/tb_mips_alu.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_alu.sv
// mips_alu: execute-stage ALU. ADD/SUB/AND/OR/illegal codes complete in one
// cycle. MUL is an unsigned shift-add taking WIDTH iteration cycles and
// producing a 2*WIDTH product. The input handshake stalls while MUL runs.
module mips_alu #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         ctrl_command,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic [WIDTH-1:0]   result,
  output logic [WIDTH-1:0]   result_hi,
  output logic               zero,
  output logic               overflow,
  output logic               illegal,
  output logic               out_valid
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_MUL
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_MUL = 4'b0010,
    OP_AND = 4'b0110,
    OP_OR  = 4'b0111
  } op_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt;
  logic [WIDTH-1:0]     mcand;
  // Product register: the upper half is the accumulator, the lower half
  // holds the multiplier. Shifting the whole register right shifts the
  // accumulator and the multiplier together, so bit 0 is always the
  // current multiplier bit and no bit is ever discarded unused.
  logic [2*WIDTH-1:0]   prod;
  logic [2*WIDTH-1:0]   prod_nxt;
  logic [WIDTH:0]       mul_sum;

  logic [WIDTH-1:0]     alu_res;
  logic                 alu_ovf;
  logic                 alu_ill;

  assign in_ready = (state == ST_IDLE);

  // One shift-add iteration: conditional add into the upper half, then shift.
  always_comb begin
    mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    prod_nxt = {mul_sum, prod[WIDTH-1:1]};
  end

  // Single-cycle operations and their flags.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (ctrl_command)
      OP_ADD: begin
        alu_res = op_a + op_b;
        alu_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = op_a - op_b;
        alu_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      default: alu_ill = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: only MUL leaves IDLE; MUL returns after the last iteration.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid && (ctrl_command == OP_MUL)) state_nxt = ST_MUL;
      ST_MUL:  if (cnt == LAST) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: result/flag registers, multiplier operands and iteration counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      mcand     <= '0;
      prod      <= '0;
      result    <= '0;
      result_hi <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      illegal   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            if (ctrl_command == OP_MUL) begin
              mcand <= op_a;
              prod  <= {{WIDTH{1'b0}}, op_b};
              cnt   <= '0;
            end else begin
              result    <= alu_res;
              result_hi <= '0;
              zero      <= (alu_res == '0);
              overflow  <= alu_ovf;
              illegal   <= alu_ill;
              out_valid <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          prod <= prod_nxt;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            result    <= prod_nxt[WIDTH-1:0];
            result_hi <= prod_nxt[2*WIDTH-1:WIDTH];
            zero      <= (prod_nxt[WIDTH-1:0] == '0);
            overflow  <= 1'b0;
            illegal   <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_alu.sv
// tb_mips_alu: directed, table-driven bench for mips_alu (WIDTH=32) plus
// hand-written sequences for back-to-back issue, issue after MUL and reset
// during MUL.
module tb_mips_alu;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ctrl_command;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] result;
  logic [31:0] result_hi;
  logic        zero;
  logic        overflow;
  logic        illegal;
  logic        out_valid;

  int checks;
  int failures;

  mips_alu #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ctrl_command (ctrl_command),
    .op_a         (op_a),
    .op_b         (op_b),
    .result       (result),
    .result_hi    (result_hi),
    .zero         (zero),
    .overflow     (overflow),
    .illegal      (illegal),
    .out_valid    (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [31:0] hi;
    logic        z;
    logic        ov;
    logic        il;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] res, input logic [31:0] hi,
                              input logic z, input logic ov, input logic il, input int lat);
    vec_t v;
    v.cmd = cmd; v.a = a; v.b = b; v.res = res; v.hi = hi;
    v.z = z; v.ov = ov; v.il = il; v.lat = lat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Issue one request, wait (bounded) for completion, check outputs and the
  // single-cycle out_valid pulse with held results afterwards.
  task automatic apply(input vec_t v, input string tag);
    int n;
    int low;
    in_valid     = 1'b1;
    ctrl_command = v.cmd;
    op_a         = v.a;
    op_b         = v.b;
    @(posedge clk); #1;
    in_valid     = 1'b0;
    ctrl_command = 4'b0001;
    op_a         = 32'hDEAD_BEEF;
    op_b         = 32'h1357_9BDF;
    n   = 1;
    low = 0;
    while (!out_valid && n < 100) begin
      if (!in_ready) low++;
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " latency"}, 64'(n), 64'(v.lat));
    chk({tag, " ready_low_cycles"}, 64'(low), 64'(v.lat - 1));
    chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, " result"}, 64'(result), 64'(v.res));
    chk({tag, " result_hi"}, 64'(result_hi), 64'(v.hi));
    chk({tag, " flags z/ov/il"}, 64'({zero, overflow, illegal}), 64'({v.z, v.ov, v.il}));
    @(posedge clk); #1;
    chk({tag, " out_valid_pulse"}, 64'(out_valid), 64'd0);
    chk({tag, " result_hold"}, 64'({result_hi, result}), {v.hi, v.res});
  endtask

  initial begin
    int bad;
    int n;
    int stray;
    checks       = 0;
    failures     = 0;
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    ctrl_command = 4'b0000;
    op_a         = '0;
    op_b         = '0;

    //           cmd      a             b             result        hi            z     ov    il   lat
    vecs.push_back(mk(4'b0000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h00000000, 1'b0, 1'b1, 1'b0, 1));
    vecs.push_back(mk(4'b0001, 32'h00000005, 32'h00000005, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0, 1));
    vecs.push_back(mk(4'b0001, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h00000000, 1'b0, 1'b1, 1'b0, 1));
    vecs.push_back(mk(4'b0010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 33));
    vecs.push_back(mk(4'b0010, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0, 33));
    vecs.push_back(mk(4'b0110, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h00000000, 1'b0, 1'b0, 1'b0, 1));
    vecs.push_back(mk(4'b0111, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1));
    vecs.push_back(mk(4'b0011, 32'hABCD1234, 32'h00001234, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b1, 1));
    vecs.push_back(mk(4'b0000, 32'h00000001, 32'h00000002, 32'h00000003, 32'h00000000, 1'b0, 1'b0, 1'b0, 1));
    vecs.push_back(mk(4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0, 1));
    vecs.push_back(mk(4'b0001, 32'h00000000, 32'h80000000, 32'h80000000, 32'h00000000, 1'b0, 1'b1, 1'b0, 1));
    vecs.push_back(mk(4'b1111, 32'h00000005, 32'h00000007, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b1, 1));
    vecs.push_back(mk(4'b0010, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001, 1'b1, 1'b0, 1'b0, 33));
    vecs.push_back(mk(4'b0010, 32'h12345678, 32'h00000009, 32'hA3D70A38, 32'h00000000, 1'b0, 1'b0, 1'b0, 33));

    // Reset state.
    #12;
    chk("reset outputs", 64'({result_hi, result}), 64'd0);
    chk("reset flags z/ov/il/ov", 64'({zero, overflow, illegal, out_valid}), 64'd0);
    chk("reset in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back AND then OR on consecutive edges.
    in_valid = 1'b1; ctrl_command = 4'b0110; op_a = 32'hF0F0F0F0; op_b = 32'hFF00FF00;
    @(posedge clk); #1;
    ctrl_command = 4'b0111;
    chk("b2b and valid", 64'(out_valid), 64'd1);
    chk("b2b and result", 64'(result), 64'hF000F000);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b or valid", 64'(out_valid), 64'd1);
    chk("b2b or result", 64'(result), 64'hFFF0FFF0);
    @(posedge clk); #1;
    chk("b2b end valid", 64'(out_valid), 64'd0);

    // Issue after MUL with noise on the inputs while it runs.
    apply(mk(4'b0000, 32'h00000007, 32'h00000000, 32'h00000007, 32'h0, 1'b0, 1'b0, 1'b0, 1), "pre");
    in_valid = 1'b1; ctrl_command = 4'b0010; op_a = 32'd3; op_b = 32'd5;
    @(posedge clk); #1;
    ctrl_command = 4'b0001; op_a = 32'h11111111; op_b = 32'h22222222;
    n = 1; bad = 0;
    while (!in_ready && n < 100) begin
      if (out_valid || result !== 32'd7 || zero !== 1'b0) bad++;
      ctrl_command = (n % 2 == 0) ? 4'b0000 : 4'b0010;
      op_a = op_a + 32'h01010101;
      @(posedge clk); #1;
      n++;
    end
    chk("mulseq hold during mul", 64'(bad), 64'd0);
    chk("mulseq ready latency", 64'(n), 64'd33);
    chk("mulseq valid with ready", 64'(out_valid), 64'd1);
    chk("mulseq product", 64'({result_hi, result}), 64'd15);
    ctrl_command = 4'b0000; op_a = 32'd10; op_b = 32'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("post-mul add valid", 64'(out_valid), 64'd1);
    chk("post-mul add result", 64'({result_hi, result}), 64'd30);

    // Reset ten cycles into a MUL.
    in_valid = 1'b1; ctrl_command = 4'b0010; op_a = 32'hFFFFFFFF; op_b = 32'hFFFFFFFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst outputs", 64'({result_hi, result}), 64'd0);
    chk("midrst flags", 64'({zero, overflow, illegal, out_valid}), 64'd0);
    chk("midrst in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    stray = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) stray++;
    end
    chk("midrst stray valid", 64'(stray), 64'd0);
    chk("midrst ready after", 64'(in_ready), 64'd1);
    apply(mk(4'b0000, 32'h00000002, 32'h00000003, 32'h00000005, 32'h0, 1'b0, 1'b0, 1'b0, 1), "postrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
